pipeline_hazard_controller: RTL and testbench

Parametrised stall/flush/redirect controller for the N-stage in-order pipeline. It replaces the hard-wired zero stalls and the two-stage nullify scheme of the current core top. It takes per-stage busy and hazard requests plus one branch/jump redirect, and drives per-stage stall, per-stage nullify and the fetch PC load. A redirect that fetch cannot take immediately is buffered until fetch is ready.

---
 rtl/pipeline_hazard_controller_if.sv | 30 +++
 rtl/pipeline_hazard_controller.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Bundle between the hazard controller and the pipeline/fetch logic.
// master drives the per-stage requests and redirect; slave is the controller.
interface pipeline_hazard_controller_if #(
    parameter int unsigned STAGES      = 5,
    parameter int unsigned STALL_CNT_W = 16
);
    logic [STAGES-1:0]      stage_valid;
    logic [STAGES-1:0]      stage_busy;
    logic [STAGES-1:0]      hazard_stall;
    logic                   redirect_req;
    logic [31:0]            redirect_pc;
    logic                   fetch_ready;
    logic [STAGES-1:0]      stall;
    logic [STAGES-1:0]      nullify;
    logic                   load_pc;
    logic [31:0]            pc;
    logic                   redirect_accepted;
    logic                   redirect_pending;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output stage_valid, stage_busy, hazard_stall, redirect_req, redirect_pc, fetch_ready,
        input  stall, nullify, load_pc, pc, redirect_accepted, redirect_pending, stall_cycles
    );

    modport slave (
        input  stage_valid, stage_busy, hazard_stall, redirect_req, redirect_pc, fetch_ready,
        output stall, nullify, load_pc, pc, redirect_accepted, redirect_pending, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/redirect controller for an N-stage in-order pipeline.
// Optional macro PIPELINE_DELAY_SLOT_EN keeps the branch delay slot alive on redirect.
module pipeline_hazard_controller #(
    parameter int unsigned STAGES         = 5,
    parameter int unsigned REDIRECT_STAGE = 2,
    parameter int unsigned STALL_CNT_W    = 16
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

`ifdef PIPELINE_DELAY_SLOT_EN
    localparam int unsigned FlushTop = REDIRECT_STAGE - 1;
`else
    localparam int unsigned FlushTop = REDIRECT_STAGE;
`endif

    state_e                 state_q, state_d;
    logic [31:0]            pend_pc_q, pend_pc_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    logic [STAGES-1:0] req;
    logic [STAGES-1:0] stall_raw;
    logic [STAGES-1:0] bubble;
    logic [STAGES-1:0] flush_mask;
    logic              accept;
    logic              load_pc_raw;
    logic              pending_raw;
    logic              pending_null;
    logic [31:0]       pc_raw;

    assign req = bus.stage_busy | bus.hazard_stall;

    // Stall propagates upstream: a stage holds if it or anything below it holds.
    always_comb begin
        stall_raw = '0;
        stall_raw[STAGES-1] = req[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            stall_raw[i] = stall_raw[i+1] | req[i];
        end
    end

    always_comb begin
        bubble = '0;
        for (int i = 0; i < int'(STAGES) - 1; i++) begin
            bubble[i+1] = stall_raw[i] & ~stall_raw[i+1];
        end
    end

    always_comb begin
        flush_mask = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            flush_mask[k] = (k <= int'(FlushTop));
        end
    end

`ifdef PIPELINE_DELAY_SLOT_EN
    // The delay slot must be fetched before the branch may leave.
    assign accept = bus.redirect_req & bus.stage_valid[REDIRECT_STAGE]
                  & bus.stage_valid[REDIRECT_STAGE-1] & ~stall_raw[REDIRECT_STAGE];
    logic unused_valid;
    assign unused_valid = ^bus.stage_valid;
`else
    assign accept = bus.redirect_req & bus.stage_valid[REDIRECT_STAGE]
                  & ~stall_raw[REDIRECT_STAGE];
    logic unused_valid;
    assign unused_valid = ^bus.stage_valid;
`endif

    always_comb begin
        state_d      = state_q;
        pend_pc_d    = pend_pc_q;
        load_pc_raw  = 1'b0;
        pending_raw  = 1'b0;
        pending_null = 1'b0;
        pc_raw       = pend_pc_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.fetch_ready) begin
                        load_pc_raw = 1'b1;
                        pc_raw      = bus.redirect_pc;
                    end else begin
                        pend_pc_d = bus.redirect_pc;
                        state_d   = StPending;
                    end
                end
            end
            StPending: begin
                // Fetch keeps producing wrong-path words until it takes the PC.
                pending_raw  = 1'b1;
                load_pc_raw  = 1'b1;
                pending_null = 1'b1;
                if (accept) begin
                    pend_pc_d = bus.redirect_pc;
                    if (bus.fetch_ready) begin
                        pc_raw = bus.redirect_pc;
                    end
                end
                if (bus.fetch_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_raw[0] && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Outputs are forced to their safe values for as long as reset is held.
    always_comb begin
        bus.stall             = '0;
        bus.nullify           = {{(STAGES-1){1'b1}}, 1'b0};
        bus.load_pc           = 1'b0;
        bus.pc                = '0;
        bus.redirect_accepted = 1'b0;
        bus.redirect_pending  = 1'b0;
        if (reset) begin
            bus.stall             = stall_raw;
            bus.nullify           = bubble | (accept ? flush_mask : '0);
            bus.nullify[1]        = bus.nullify[1] | pending_null;
            bus.load_pc           = load_pc_raw;
            bus.pc                = pc_raw;
            bus.redirect_accepted = accept;
            bus.redirect_pending  = pending_raw;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench for pipeline_hazard_controller (STAGES=5, REDIRECT_STAGE=2).
module tb_pipeline_hazard_controller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pipeline_hazard_controller_if #(.STAGES(5), .STALL_CNT_W(16)) dut_if ();
    pipeline_hazard_controller_if #(.STAGES(5), .STALL_CNT_W(3))  sat_if ();

    pipeline_hazard_controller #(
        .STAGES(5), .REDIRECT_STAGE(2), .STALL_CNT_W(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    // Narrow counter copy, used only to reach saturation quickly.
    pipeline_hazard_controller #(
        .STAGES(5), .REDIRECT_STAGE(2), .STALL_CNT_W(3)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sat_if.slave)
    );

    assign sat_if.stage_valid  = dut_if.stage_valid;
    assign sat_if.stage_busy   = dut_if.stage_busy;
    assign sat_if.hazard_stall = dut_if.hazard_stall;
    assign sat_if.redirect_req = dut_if.redirect_req;
    assign sat_if.redirect_pc  = dut_if.redirect_pc;
    assign sat_if.fetch_ready  = dut_if.fetch_ready;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        dut_if.stage_valid  = '0;
        dut_if.stage_busy   = '0;
        dut_if.hazard_stall = '0;
        dut_if.redirect_req = 1'b0;
        dut_if.redirect_pc  = '0;
        dut_if.fetch_ready  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target, input logic ready);
        @(negedge clk);
        clear_inputs();
        dut_if.stage_valid  = 5'b00100;
        dut_if.redirect_req = 1'b1;
        dut_if.redirect_pc  = target;
        dut_if.fetch_ready  = ready;
        #1;
    endtask

    task automatic idle_cycle(input logic ready);
        @(negedge clk);
        clear_inputs();
        dut_if.redirect_pc = 32'hdead_beef;
        dut_if.fetch_ready = ready;
        #1;
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        n_checks = 0;
        n_errors = 0;
        clear_inputs();

        // Reset forces outputs even with active-looking inputs.
        @(negedge clk);
        dut_if.stage_valid  = 5'b11111;
        dut_if.stage_busy   = 5'b11111;
        dut_if.redirect_req = 1'b1;
        dut_if.redirect_pc  = 32'h1234_5678;
        dut_if.fetch_ready  = 1'b1;
        #1;
        check_eq("rst_stall", 32'(dut_if.stall), 32'h0);
        check_eq("rst_nullify", 32'(dut_if.nullify), 32'h1e);
        check_eq("rst_load_pc", 32'(dut_if.load_pc), 32'h0);
        check_eq("rst_pc", dut_if.pc, 32'h0);
        check_eq("rst_acc", 32'(dut_if.redirect_accepted), 32'h0);
        check_eq("rst_pend", 32'(dut_if.redirect_pending), 32'h0);
        check_eq("rst_cnt", 32'(dut_if.stall_cycles), 32'h0);
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;

        // Single-cycle load-use hazard in stage 1.
        @(negedge clk);
        dut_if.hazard_stall = 5'b00010;
        #1;
        check_eq("t1_stall", 32'(dut_if.stall), 32'h03);
        check_eq("t1_nullify", 32'(dut_if.nullify), 32'h04);
        check_eq("t1_cnt0", 32'(dut_if.stall_cycles), 32'h0);
        idle_cycle(1'b0);
        check_eq("t1_cnt1", 32'(dut_if.stall_cycles), 32'h1);
        check_eq("t1_stall_off", 32'(dut_if.stall), 32'h0);

        // Memory busy in stage 3 for three cycles.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dut_if.stage_busy = 5'b01000;
            #1;
            check_eq("t2_stall", 32'(dut_if.stall), 32'h0f);
            check_eq("t2_nullify", 32'(dut_if.nullify), 32'h10);
        end
        idle_cycle(1'b0);
        check_eq("t2_cnt", 32'(dut_if.stall_cycles), 32'h3);

        // Redirect taken immediately.
        redirect(32'h0040_0100, 1'b1);
        check_eq("t3_load_pc", 32'(dut_if.load_pc), 32'h1);
        check_eq("t3_pc", dut_if.pc, 32'h0040_0100);
        check_eq("t3_nullify", 32'(dut_if.nullify), 32'h06);
        check_eq("t3_acc", 32'(dut_if.redirect_accepted), 32'h1);
        idle_cycle(1'b0);
        check_eq("t3_pend", 32'(dut_if.redirect_pending), 32'h0);
        check_eq("t3_load_pc_off", 32'(dut_if.load_pc), 32'h0);

        // Redirect buffered while fetch is not ready.
        redirect(32'h0040_0100, 1'b0);
        check_eq("t4_acc", 32'(dut_if.redirect_accepted), 32'h1);
        check_eq("t4_nullify_acc", 32'(dut_if.nullify), 32'h06);
        check_eq("t4_pend_acc", 32'(dut_if.redirect_pending), 32'h0);
        for (int c = 0; c < 3; c++) begin
            idle_cycle(c == 2);
            check_eq("t4_pend", 32'(dut_if.redirect_pending), 32'h1);
            check_eq("t4_load_pc", 32'(dut_if.load_pc), 32'h1);
            check_eq("t4_pc", dut_if.pc, 32'h0040_0100);
            check_eq("t4_nullify", 32'(dut_if.nullify), 32'h02);
        end
        idle_cycle(1'b0);
        check_eq("t4_back_idle", 32'(dut_if.redirect_pending), 32'h0);
        check_eq("t4_load_pc_off", 32'(dut_if.load_pc), 32'h0);

        // Reset in the middle of PENDING drops the redirect and the counter.
        redirect(32'h0040_0100, 1'b0);
        idle_cycle(1'b0);
        check_eq("t4r_pend_before", 32'(dut_if.redirect_pending), 32'h1);
        check_eq("t4r_cnt_before", 32'(dut_if.stall_cycles), 32'h3);
        reset = 1'b0;
        #1;
        check_eq("t4r_pend", 32'(dut_if.redirect_pending), 32'h0);
        check_eq("t4r_cnt", 32'(dut_if.stall_cycles), 32'h0);
        check_eq("t4r_pc", dut_if.pc, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycle(1'b0);
        check_eq("t4r_discarded", 32'(dut_if.redirect_pending), 32'h0);

        // Downstream busy defers the redirect.
        for (int c = 0; c < 3; c++) begin
            redirect(32'h0040_0200, 1'b1);
            dut_if.stage_busy = (c < 2) ? 5'b01000 : 5'b00000;
            #1;
            check_eq("t5_acc", 32'(dut_if.redirect_accepted), (c < 2) ? 32'h0 : 32'h1);
            check_eq("t5_load_pc", 32'(dut_if.load_pc), (c < 2) ? 32'h0 : 32'h1);
            check_eq("t5_nullify", 32'(dut_if.nullify), (c < 2) ? 32'h10 : 32'h06);
        end
        check_eq("t5_pc", dut_if.pc, 32'h0040_0200);

        // Newer redirect overwrites pending one; stall does not cancel PENDING.
        redirect(32'h0000_0a00, 1'b0);
        redirect(32'h0000_0c00, 1'b0);
        check_eq("ow_pc_old", dut_if.pc, 32'h0000_0a00);
        check_eq("ow_pend", 32'(dut_if.redirect_pending), 32'h1);
        @(negedge clk);
        clear_inputs();
        dut_if.stage_busy = 5'b01000;
        #1;
        check_eq("ow_pc_new", dut_if.pc, 32'h0000_0c00);
        check_eq("ow_nullify_stall", 32'(dut_if.nullify), 32'h12);
        idle_cycle(1'b0);
        check_eq("ow_pend_kept", 32'(dut_if.redirect_pending), 32'h1);
        redirect(32'h0000_0e00, 1'b1);
        check_eq("bypass_pc", dut_if.pc, 32'h0000_0e00);
        check_eq("bypass_nullify", 32'(dut_if.nullify), 32'h06);
        idle_cycle(1'b0);
        check_eq("bypass_idle", 32'(dut_if.redirect_pending), 32'h0);

        // Delay-slot dependence on stage_valid[1].
        @(negedge clk);
        clear_inputs();
        dut_if.stage_valid  = 5'b00101;
        dut_if.redirect_req = 1'b1;
        dut_if.redirect_pc  = 32'h0000_1000;
        dut_if.fetch_ready  = 1'b1;
        #1;
`ifdef PIPELINE_DELAY_SLOT_EN
        check_eq("ds_no_acc", 32'(dut_if.redirect_accepted), 32'h0);
        check_eq("ds_no_load", 32'(dut_if.load_pc), 32'h0);
        @(negedge clk);
        dut_if.stage_valid = 5'b00111;
        #1;
        check_eq("ds_acc", 32'(dut_if.redirect_accepted), 32'h1);
        check_eq("ds_nullify", 32'(dut_if.nullify), 32'h02);
`else
        check_eq("nds_acc", 32'(dut_if.redirect_accepted), 32'h1);
        check_eq("nds_nullify", 32'(dut_if.nullify), 32'h06);
`endif

        // Counter saturation on the 3-bit instance.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            dut_if.hazard_stall = 5'b00001;
        end
        idle_cycle(1'b0);
        check_eq("sat_wide", 32'(dut_if.stall_cycles), 32'd10);
        check_eq("sat_narrow", 32'(sat_if.stall_cycles), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
